fifo_read_scheduler: RTL

Shares a single FIFO read port among NUM_REQ consumers, each requesting a burst of a given word count. Round-robin arbitration picks one requester. The block then pops that many words, stalling while the FIFO is empty, and returns the data with a valid strobe and a per-requester done pulse. It sits between the shared transfer FIFO and the per-channel transfer controllers, and extends the single-consumer start/read_en/busy/done sequencing to multiple clients.

---
 rtl/fifo_sched_pkg.sv | 16 +
 rtl/fifo_read_scheduler_rr_arbiter.sv | 31 +++
 rtl/fifo_read_scheduler.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and default widths for the
// multi-consumer FIFO read scheduler.
package fifo_sched_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int NUM_REQ_DEF = 4;
  localparam int LEN_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/fifo_read_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search
// starts one past the previous winner and wraps.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // first set request after last_grant wins
  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_read_scheduler.sv
// Shares one FIFO read port among NUM_REQ burst
// consumers with round-robin arbitration.
module fifo_read_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic                     fifo_empty,
  input  logic [DATA_W-1:0]        fifo_dout,
  output logic                     fifo_rd_en,
  output logic [NUM_REQ-1:0]       grant,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  state_t             state_nx;
  logic [LEN_W-1:0]   remaining;
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  logic               pop;
  logic               rd_q;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req       (req),
    .last_grant(last_grant),
    .grant     (win),
    .grant_idx (win_idx)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state; a zero-length burst skips the
  // pops, and DRAIN lasts one cycle because the
  // final pop is then in stage 1 and reaches
  // data_out exactly during DONE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (|req) state_nx = XFER;
      XFER: begin
        if (remaining == '0)
          state_nx = DONE;
        else if (pop && remaining == LEN_W'(1))
          state_nx = DRAIN;
      end
      DRAIN: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs; pop is masked by rst so an
  // interrupted burst never consumes a word
  always_comb begin
    pop = (state == XFER) && !fifo_empty &&
          (remaining != '0) && !rst;
    fifo_rd_en = pop;
    busy       = (state != IDLE);
    done       = (state == DONE) ? grant : '0;
  end

  // burst ownership and word countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      remaining  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant      <= win;
            last_grant <= win_idx;
            remaining  <=
              req_len[int'(win_idx)*LEN_W +: LEN_W];
          end
        end
        XFER: if (pop) remaining <= remaining - LEN_W'(1);
        DONE: grant <= '0;
        default: ;
      endcase
    end
  end

  // two-stage read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      rd_q       <= pop;
      data_valid <= rd_q;
      data_out   <= fifo_dout;
    end
  end

endmodule
